avalon_mem_test_master: RTL and testbench

- Avalon-MM master that drives the 32-bit single-port on-chip memory slave (10-bit word address, byteenable, chipselect, fixed read latency).
- On a start pulse it writes a deterministic pattern over an address range, reads the range back and compares each word.
- Reports the pass/fail result, the mismatch count and the first failing address.
- Used for power-on memory self-test and as the bus initiator in memory-subsystem simulation.

---
 rtl/avalon_mem_if.sv | 31 +++
 rtl/avalon_mem_test_master.sv | 178 +++++++++++++++++
 tb/tb_avalon_mem_test_master.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_mem_if.sv
// Avalon-MM request/response bundle between the memory test master and a
// single-port word-addressed memory slave.
interface avalon_mem_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // Handshake: a request (read or write with chipselect) is presented by the
  // master and held stable; it is accepted on the rising edge where it is
  // asserted and waitrequest is 0. Read data returns a fixed number of cycles
  // after the accept edge, and only one read is outstanding at a time.
  logic [ADDR_W-1:0]   avm_address;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_chipselect;
  logic                avm_write;
  logic                avm_read;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_waitrequest;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_read,
           avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_read,
           avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/avalon_mem_test_master.sv
// Memory self-test master: writes seed+i over a wrapping address range, reads it
// back one word at a time and reports mismatch count and first failing address.
module avalon_mem_test_master #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   fail_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [2:0]        dbg_state,
  avalon_mem_if.master      bus
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WRITE      = 3'd1,
    S_READ_ISSUE = 3'd2,
    S_READ_WAIT  = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d, n_q, n_d, fail_q, fail_d, n_clamped;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d, ffa_q, ffa_d;
  logic [DATA_W-1:0] seed_q, seed_d, wdata_q, wdata_d, exp_data;
  logic [1:0]        lat_q, lat_d;
  logic              wr_q, wr_d, rd_q, rd_d, cs_q, pass_q, pass_d, last_beat;
  logic [BE_W-1:0]   be_q;

  assign n_clamped = (word_count > MAX_N) ? MAX_N : word_count;
  assign exp_data  = seed_q + DATA_W'(idx_q);
  assign last_beat = (idx_q == n_q - 1'b1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    base_d  = base_q;
    seed_d  = seed_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lat_d   = lat_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    fail_d  = fail_q;
    ffa_d   = ffa_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base_addr;
          seed_d = seed;
          n_d    = n_clamped;
          idx_d  = '0;
          fail_d = '0;
          ffa_d  = '0;
          pass_d = 1'b0;
          if (n_clamped == '0) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = S_WRITE;
            wr_d    = 1'b1;
            addr_d  = base_addr;
            wdata_d = seed;
          end
        end
      end
      S_WRITE: begin
        if (!bus.avm_waitrequest) begin
          if (last_beat) begin
            state_d = S_READ_ISSUE;
            idx_d   = '0;
            wr_d    = 1'b0;
            rd_d    = 1'b1;
            addr_d  = base_q;
          end else begin
            idx_d   = idx_q + 1'b1;
            addr_d  = addr_q + 1'b1;
            wdata_d = wdata_q + 1'b1;
          end
        end
      end
      S_READ_ISSUE: begin
        if (!bus.avm_waitrequest) begin
          state_d = S_READ_WAIT;
          rd_d    = 1'b0;
          lat_d   = '0;
        end
      end
      S_READ_WAIT: begin
        // addr_q still holds addr(i) here, so it doubles as the failing address.
        if (lat_q == LAT_LAST) begin
          if (bus.avm_readdata != exp_data) begin
            fail_d = fail_q + 1'b1;
            if (fail_q == '0) ffa_d = addr_q;
          end
          if (last_beat) begin
            state_d = S_DONE;
            pass_d  = (fail_d == '0);
          end else begin
            state_d = S_READ_ISSUE;
            idx_d   = idx_q + 1'b1;
            addr_d  = addr_q + 1'b1;
            rd_d    = 1'b1;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      base_q  <= '0;
      seed_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lat_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      cs_q    <= 1'b0;
      be_q    <= '0;
      fail_q  <= '0;
      ffa_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      base_q  <= base_d;
      seed_q  <= seed_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lat_q   <= lat_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cs_q    <= wr_d | rd_d;
      be_q    <= {BE_W{wr_d | rd_d}};
      fail_q  <= fail_d;
      ffa_q   <= ffa_d;
      pass_q  <= pass_d;
    end
  end

  assign busy            = (state_q == S_WRITE) || (state_q == S_READ_ISSUE) ||
                           (state_q == S_READ_WAIT);
  assign done            = (state_q == S_DONE);
  assign pass            = pass_q;
  assign fail_count      = fail_q;
  assign first_fail_addr = ffa_q;
  assign dbg_state       = state_q;

  assign bus.avm_address    = addr_q;
  assign bus.avm_byteenable = be_q;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_write      = wr_q;
  assign bus.avm_read       = rd_q;
  assign bus.avm_writedata  = wdata_q;
endmodule

// File: tb/tb_avalon_mem_test_master.sv
// Bench for avalon_mem_test_master: instance A (read latency 1) with a stalling,
// fault-injecting memory; instance B (read latency 3) with an exact-timing memory.
module tb_avalon_mem_test_master;
  localparam int AW = 10;
  localparam int DW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_a = 1'b0, start_b = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic [DW-1:0] seed = '0;
  logic          busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [AW:0]   fc_a, fc_b;
  logic [AW-1:0] ffa_a, ffa_b;
  logic [2:0]    dbg_a, dbg_b;

  avalon_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  avalon_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  avalon_mem_test_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start_a), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy_a), .done(done_a),
    .pass(pass_a), .fail_count(fc_a), .first_fail_addr(ffa_a),
    .dbg_state(dbg_a), .bus(bus_a.master)
  );

  avalon_mem_test_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3)) dut_l3 (
    .clk(clk), .reset_n(reset_n), .start(start_b), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy_b), .done(done_b),
    .pass(pass_b), .fail_count(fc_b), .first_fail_addr(ffa_b),
    .dbg_state(dbg_b), .bus(bus_b.master)
  );

  int total = 0;
  int bad = 0;
  logic [42:0] exp_q[$];  // {is_read, addr, wdata} per accepted request on A
  logic [37:0] res_q[$];  // {pass, fail_count, first_fail_addr, cycles}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // memory model A: latency 1, optional bit0 fault at 5/9, optional stalls
  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] rdata_a;
  logic          fault_en = 1'b0, stall_en = 1'b0, wait_a, prev_stall = 1'b0;
  int            req_idx = 0, wait_cyc = 0;
  logic [48:0]   req_a, saved_a;
  assign req_a = {bus_a.avm_address, bus_a.avm_write, bus_a.avm_read, bus_a.avm_chipselect,
                  bus_a.avm_byteenable, bus_a.avm_writedata};
  assign wait_a = stall_en && bus_a.avm_chipselect && req_idx[0] && (wait_cyc < 2);
  assign bus_a.avm_waitrequest = wait_a;
  assign bus_a.avm_readdata = rdata_a;

  always @(posedge clk) begin
    if (prev_stall) check("stall_hold", 64'(req_a), 64'(saved_a));
    prev_stall <= bus_a.avm_chipselect && wait_a;
    saved_a <= req_a;
    if (bus_a.avm_chipselect && !wait_a) begin
      if (bus_a.avm_write) mem_a[bus_a.avm_address] <= bus_a.avm_writedata;
      if (bus_a.avm_read)
        rdata_a <= mem_a[bus_a.avm_address] ^
                   {31'd0, fault_en && (bus_a.avm_address == 10'd5 || bus_a.avm_address == 10'd9)};
    end
    if (!stall_en) begin
      req_idx <= 0;
      wait_cyc <= 0;
    end else if (bus_a.avm_chipselect) begin
      if (wait_a) wait_cyc <= wait_cyc + 1;
      else begin
        req_idx <= req_idx + 1;
        wait_cyc <= 0;
      end
    end
  end

  // memory model B: data valid only in the cycle before the 3rd edge after accept
  logic [DW-1:0] mem_b [1024];
  logic [DW-1:0] d1, d2, d3;
  logic          v1 = 1'b0, v2 = 1'b0, v3 = 1'b0, early_b = 1'b0;
  localparam logic [DW-1:0] GARB = 32'hDEAD_BEEF;
  assign bus_b.avm_waitrequest = 1'b0;
  assign bus_b.avm_readdata = early_b ? (v2 ? d2 : GARB) : (v3 ? d3 : GARB);

  always @(posedge clk) begin
    if (bus_b.avm_chipselect && bus_b.avm_write) mem_b[bus_b.avm_address] <= bus_b.avm_writedata;
    v1 <= bus_b.avm_chipselect && bus_b.avm_read;
    d1 <= mem_b[bus_b.avm_address];
    v2 <= v1; d2 <= d1;
    v3 <= v2; d3 <= d2;
  end

  // monitor: accepted requests on A against the expected queue
  always @(negedge clk) begin
    if (reset_n && bus_a.avm_chipselect && !wait_a) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL bus_unexpected actual=addr %0d required=no request", bus_a.avm_address);
      end else begin
        logic [42:0] e;
        e = exp_q.pop_front();
        check("bus_read", 64'(bus_a.avm_read), 64'(e[42]));
        check("bus_write", 64'(bus_a.avm_write), 64'(!e[42]));
        check("bus_addr", 64'(bus_a.avm_address), 64'(e[41:32]));
        check("bus_be", 64'(bus_a.avm_byteenable), 64'hF);
        if (!e[42]) check("bus_wdata", 64'(bus_a.avm_writedata), 64'(e[31:0]));
      end
    end
  end

  // monitor: completion results of whichever instance pulses done
  int cyc = 0;
  always @(negedge clk) begin
    if (!reset_n) cyc = 0;
    else begin
      if (busy_a || done_a || busy_b || done_b) cyc++;
      if (done_a || done_b) begin
        if (res_q.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected actual=done required=no done");
        end else begin
          logic [37:0] r;
          r = res_q.pop_front();
          check("res_pass", 64'(done_a ? pass_a : pass_b), 64'(r[37]));
          check("res_fail_count", 64'(done_a ? fc_a : fc_b), 64'(r[36:26]));
          check("res_first_fail", 64'(done_a ? ffa_a : ffa_b), 64'(r[25:16]));
          check("res_cycles", 64'(cyc), 64'(r[15:0]));
        end
        cyc = 0;
      end
    end
  end

  // driver tasks
  task automatic launch(input bit sel, input logic [AW-1:0] b, input logic [AW:0] wc,
                        input logic [DW-1:0] sd, input int n, input bit ep,
                        input logic [AW:0] efc, input logic [AW-1:0] effa, input int ecyc);
    res_q.push_back({ep, efc, effa, 16'(ecyc)});
    if (!sel) begin
      for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 10'(b + i), 32'(sd + i)});
      for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 10'(b + i), 32'h0});
    end
    @(negedge clk);
    base_addr = b; word_count = wc; seed = sd;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      if (sel ? done_b : done_a) break;
      @(negedge clk);
    end
    if (k == limit) begin
      total++; bad++;
      $display("FAIL done_timeout actual=no done required=done within %0d cycles", limit);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy_a), 0);
    check({tag, "_done"}, 64'(done_a), 0);
    check({tag, "_pass"}, 64'(pass_a), 0);
    check({tag, "_fail_count"}, 64'(fc_a), 0);
    check({tag, "_first_fail"}, 64'(ffa_a), 0);
    check({tag, "_bus"}, 64'(req_a), 0);
    check({tag, "_b_busy_done"}, 64'({busy_b, done_b, bus_b.avm_chipselect}), 0);
  endtask

  initial begin
    #1_000_000;
    total++; bad++;
    $display("FAIL watchdog actual=still running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // clean run: 4 writes, 4 reads of 2 cycles, 1 done cycle
    launch(0, 10'd0, 11'd4, 32'h1000_0000, 4, 1, 11'd0, 10'd0, 13);
    wait_done(0, 100);

    // injected bit0 faults at 5 and 9
    fault_en = 1'b1;
    launch(0, 10'd4, 11'd8, 32'hA5A5_0000, 8, 0, 11'd2, 10'd5, 25);
    wait_done(0, 100);
    fault_en = 1'b0;

    // wrap plus 2-cycle stalls on every 2nd request: 13 + 4*2 cycles
    stall_en = 1'b1;
    launch(0, 10'd1022, 11'd4, 32'h0000_00FF, 4, 1, 11'd0, 10'd0, 21);
    wait_done(0, 100);
    stall_en = 1'b0;

    // N=0: done in the cycle right after the start edge, no bus traffic
    launch(0, 10'd7, 11'd0, 32'h0, 0, 1, 11'd0, 10'd0, 1);
    check("n0_done_next_cycle", 64'(done_a), 1);
    wait_done(0, 5);

    // full memory, exact and clamped counts
    launch(0, 10'd512, 11'd1024, 32'hCAFE_0000, 1024, 1, 11'd0, 10'd0, 3073);
    wait_done(0, 4000);
    launch(0, 10'd0, 11'd2047, 32'h1234_5678, 1024, 1, 11'd0, 10'd0, 3073);
    wait_done(0, 4000);

    // start while busy and in the DONE cycle is ignored
    launch(0, 10'd16, 11'd4, 32'h0000_0055, 4, 1, 11'd0, 10'd0, 13);
    repeat (3) @(negedge clk);
    base_addr = 10'd100; word_count = 11'd1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, 100);
    base_addr = 10'd200; word_count = 11'd1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("done_start_ignored_busy", 64'(busy_a), 0);
    @(negedge clk);
    check("done_start_ignored_busy2", 64'({busy_a, done_a}), 0);

    // asynchronous reset in READ_WAIT aborts without done
    launch(0, 10'd0, 11'd8, 32'h0BAD_F00D, 8, 1, 11'd0, 10'd0, 25);
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        if (dbg_a == 3'd3) break;
        @(negedge clk);
      end
      check("reach_read_wait", 64'(dbg_a), 3);
    end
    #2 reset_n = 1'b0;
    #1 check_idle_outputs("abort");
    exp_q.delete();
    res_q.delete();
    repeat (3) @(negedge clk);
    check("abort_no_done", 64'(done_a), 0);
    reset_n = 1'b1;
    launch(0, 10'd3, 11'd2, 32'h0000_0200, 2, 1, 11'd0, 10'd0, 7);
    wait_done(0, 100);

    // latency 3: exact sampling edge, and data one cycle early mismatches
    launch(1, 10'd10, 11'd3, 32'h0000_0077, 0, 1, 11'd0, 10'd0, 16);
    wait_done(1, 100);
    early_b = 1'b1;
    launch(1, 10'd20, 11'd3, 32'h0000_0088, 0, 0, 11'd3, 10'd20, 16);
    wait_done(1, 100);
    early_b = 1'b0;

    repeat (3) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 0);
    check("res_q_drained", 64'(res_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
